// File: rtl/hdmi_text_pkg.sv
// Shared constants, control-word bit positions and the 12-bit colour type
// for the 80x30 text-mode renderer.
package hdmi_text_pkg;

  localparam int COLS            = 80;
  localparam int ROWS            = 30;
  localparam int GLYPH_W         = 8;
  localparam int GLYPH_H         = 16;
  localparam int VRAM_CHAR_WORDS = 600;
  localparam int CTRL_IDX        = 600;
  localparam int FRAME_IDX       = 601;

  localparam int CURSOR_EN = 31;
  localparam int FG_MSB    = 24;
  localparam int BG_MSB    = 12;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Colour fields are packed r,g,b from msb downwards.
  function automatic rgb12_t rgb_from_ctrl(input logic [31:0] ctrl, input int msb);
    rgb12_t c;
    c.r = ctrl[msb -: 4];
    c.g = ctrl[msb-4 -: 4];
    c.b = ctrl[msb-8 -: 4];
    return c;
  endfunction

endpackage

// File: rtl/text_blink_timer.sv
// Frame counter clocked by vsync rising edges; one counter bit is the
// cursor blink phase.
module text_blink_timer #(
  parameter int BLINK_BIT = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_blink_phase
);

  logic       r_vsync_q;
  logic [5:0] r_frame_cnt;
  logic       w_vsync_rise;

  assign w_vsync_rise  = i_vsync & ~r_vsync_q;
  assign o_blink_phase = r_frame_cnt[BLINK_BIT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vsync_q   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vsync_q <= i_vsync;
      if (w_vsync_rise)
        r_frame_cnt <= r_frame_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/text_render_pipe.sv
// Three-stage raster-to-RGB pipeline: VRAM char fetch, font row fetch,
// colour select. blank/vsync ride along to stay aligned with RGB.
module text_render_pipe
  import hdmi_text_pkg::*;
#(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int VRAM_AW   = 10,
  parameter int BLINK_BIT = 5
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic [9:0]         drawX,
  input  logic [9:0]         drawY,
  input  logic               pixel_onoff,
  input  logic               vsync,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [31:0]        vram_rdata,
  input  logic [31:0]        ctrl_reg,
  input  logic [11:0]        cursor_idx,
  output logic [10:0]        font_addr,
  input  logic [7:0]         font_data,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               blank_out,
  output logic               vsync_out
);

  logic [11:0] w_idx;
  logic        w_onscreen;
  logic [7:0]  w_byte;
  logic        w_blink_phase;
  logic        w_pix_on;
  logic        w_unused_ctrl;

  logic [1:0]  r1_lane;
  logic [3:0]  r1_row;
  logic [2:0]  r1_col;
  logic        r1_onscreen, r1_cur, r1_blank, r1_vs;

  logic [2:0]  r2_col;
  logic        r2_inv, r2_cur, r2_onscreen, r2_blank, r2_vs;

  rgb12_t      r3_rgb;
  logic        r3_blank, r3_vs;

  assign w_onscreen = (32'(drawX) < COLS * GLYPH_W) && (32'(drawY) < ROWS * GLYPH_H);
  assign w_idx      = 12'(drawY[9:4]) * 12'(COLS) + 12'(drawX[9:3]);
  assign vram_addr  = w_onscreen ? VRAM_AW'(w_idx >> 2) : '0;

  assign w_byte    = vram_rdata[{r1_lane, 3'b000} +: 8];
  assign font_addr = {w_byte[6:0], r1_row};

  assign w_pix_on = font_data[3'd7 - r2_col] ^ r2_inv ^ (r2_cur & ctrl_reg[CURSOR_EN]);

  assign w_unused_ctrl = &{ctrl_reg[30:25], ctrl_reg[0]};

  text_blink_timer #(.BLINK_BIT(BLINK_BIT)) u_blink (
    .i_clk         (S_AXI_ACLK),
    .i_rst_n       (S_AXI_ARESETN),
    .i_vsync       (vsync),
    .o_blink_phase (w_blink_phase)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r1_lane     <= '0;
      r1_row      <= '0;
      r1_col      <= '0;
      r1_onscreen <= 1'b0;
      r1_cur      <= 1'b0;
      r1_blank    <= 1'b0;
      r1_vs       <= 1'b0;
      r2_col      <= '0;
      r2_inv      <= 1'b0;
      r2_cur      <= 1'b0;
      r2_onscreen <= 1'b0;
      r2_blank    <= 1'b0;
      r2_vs       <= 1'b0;
      r3_rgb      <= '0;
      r3_blank    <= 1'b0;
      r3_vs       <= 1'b0;
    end else begin
      r1_lane     <= w_idx[1:0];
      r1_row      <= drawY[3:0];
      r1_col      <= drawX[2:0];
      r1_onscreen <= w_onscreen;
      r1_cur      <= (w_idx == cursor_idx);
      r1_blank    <= pixel_onoff;
      r1_vs       <= vsync;

      // Blink phase is folded in here so a same-cycle vsync edge lands one pixel later.
      r2_col      <= r1_col;
      r2_inv      <= w_byte[7];
      r2_cur      <= r1_cur & w_blink_phase;
      r2_onscreen <= r1_onscreen;
      r2_blank    <= r1_blank;
      r2_vs       <= r1_vs;

      if (!r2_blank || !r2_onscreen)
        r3_rgb <= '0;
      else if (w_pix_on)
        r3_rgb <= rgb_from_ctrl(ctrl_reg, FG_MSB);
      else
        r3_rgb <= rgb_from_ctrl(ctrl_reg, BG_MSB);
      r3_blank <= r2_blank;
      r3_vs    <= r2_vs;
    end
  end

  assign red       = r3_rgb.r;
  assign green     = r3_rgb.g;
  assign blue      = r3_rgb.b;
  assign blank_out = r3_blank;
  assign vsync_out = r3_vs;

endmodule
